pcpi_initiator: RTL and testbench
=================================

Name: pcpi_initiator

Overview:
CPU-side master for the PCPI coprocessor interface. It accepts an R-type M-extension command (funct3, rs1, rs2) on a valid/ready request channel, encodes `pcpi_insn`, and drives the PCPI handshake until the coprocessor responds. It then returns the result on a valid/ready response channel. It drives the MUL/DIV coprocessors from bus-side logic and from standalone throughput benches, and it flags unclaimed instructions.

Parameters:
- FUNCT7, 7'b0000001, funct7 field placed in `pcpi_insn[31:25]`.
- OPCODE, 7'b0110011, opcode field placed in `pcpi_insn[6:0]`.
- CLAIM_TIMEOUT, 16, number of `pcpi_valid` cycles without `pcpi_wait`/`pcpi_ready` before the instruction is declared unclaimed (legal range 2..255).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  reset; one clock, asynchronous assert, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with `cmd_valid`.
- cmd_funct3  in  3  operation select.
- cmd_rs1  in  32  operand 1.
- cmd_rs2  in  32  operand 2.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  32  result.
- rsp_wr  out  1  coprocessor asserted `pcpi_wr` with `pcpi_ready`.
- rsp_err  out  1  instruction unclaimed (timeout).
- perf_cycles  out  16  cycles of last PCPI transaction (see Optional Feature).
- pcpi_valid  out  1  instruction presented.
- pcpi_insn  out  32  encoded instruction.
- pcpi_rs1  out  32  operand 1 to coprocessor.
- pcpi_rs2  out  32  operand 2 to coprocessor.
- pcpi_wr  in  1  result write enable.
- pcpi_rd  in  32  result.
- pcpi_wait  in  1  coprocessor claims instruction, still busy.
- pcpi_ready  in  1  single-cycle completion pulse.

Behaviour:
- **Reset values.** On `resetn` low (asynchronous):
  - state = IDLE.
  - `pcpi_valid`, `rsp_valid`, `rsp_wr`, `rsp_err` = 0.
  - `pcpi_insn`, `pcpi_rs1`, `pcpi_rs2`, `rsp_data`, `perf_cycles` = 0.
  - Claim counter and claimed flag = 0.
- **Encoding.** `pcpi_insn` = {FUNCT7, cmd_rs2[4:0], cmd_rs1[4:0], cmd_funct3, 5'b00000, OPCODE}. It is latched with the operands at acceptance. All eight funct3 values are passed through unchecked.
- **Registered outputs.** All outputs are registered. `cmd_ready` = (state==IDLE).
- **IDLE.** On `cmd_valid && cmd_ready`:
  - Latch `pcpi_rs1`/`pcpi_rs2`/`pcpi_insn`.
  - Set `pcpi_valid`=1 from the next cycle.
  - Clear the counter and the claimed flag.
  - Go to ISSUE.
- **ISSUE.** `pcpi_valid`=1; `pcpi_insn`/`pcpi_rs1`/`pcpi_rs2` are held stable. Each cycle, in priority order:
  1. If `pcpi_ready`: `rsp_data` = `pcpi_wr` ? `pcpi_rd` : 0; `rsp_wr` = `pcpi_wr`; `rsp_err` = 0. Go to RESP. `pcpi_valid` is low on the following cycle.
  2. Else if `pcpi_wait`: set the claimed flag. The counter stops and no timeout is possible for this instruction.
  3. Else if not claimed and counter == CLAIM_TIMEOUT-1: `rsp_data`=0, `rsp_wr`=0, `rsp_err`=1. Go to RESP and drop `pcpi_valid`.
  4. Else, if not claimed: counter increments.
- **Tie-break.** If `pcpi_ready` arrives in the same cycle as the timeout condition, `pcpi_ready` wins.
- **Unbounded wait after claim.** After a claim, the block waits indefinitely for `pcpi_ready`. Deassertion of `pcpi_wait` after a claim does not re-arm the timeout.
- **RESP.** `rsp_valid`=1. `rsp_data`/`rsp_wr`/`rsp_err` are held stable until `rsp_ready`. On `rsp_ready`, `rsp_valid` goes to 0 next cycle and state goes to IDLE.
- **No overlap.** `cmd_ready` is low throughout ISSUE and RESP, so at most one command is in flight.
- **Latency.**
  - `pcpi_valid` rises 1 cycle after command acceptance.
  - `rsp_valid` rises 1 cycle after `pcpi_ready` is sampled.
  - Minimum command-to-response latency is 2 cycles with a zero-wait coprocessor.
- **Stray signals.** `pcpi_ready`/`pcpi_wait` in IDLE or RESP are ignored.
- **Reset mid-operation.** Any state returns to IDLE with all outputs at reset values immediately; the pending response is lost.

Optional Feature:
- **Macro:** `PCPI_PERF_EN`.
- **With the macro defined:**
  - An internal 16-bit counter counts cycles with `pcpi_valid` high, inclusive of the cycle `pcpi_ready` is sampled, or of the timeout cycle.
  - The count saturates at 16'hFFFF.
  - It is copied to `perf_cycles` on entry to RESP and held until the next RESP entry.
- **Without the macro:** `perf_cycles` is tied to 16'h0000 and the counter logic is absent.
- The port exists in both builds.

Test Plan:
1. **DIV 20/3, zero-wait path.** Stimulus: cmd funct3=3'b100, rs1=20, rs2=3, with the divider coprocessor attached. Required: `pcpi_insn`=32'h023A4033 while `pcpi_valid`; `rsp_data`=6; `rsp_wr`=1; `rsp_err`=0; `pcpi_valid` low the cycle after `pcpi_ready`.
2. **Unclaimed instruction.** Stimulus: stub that never asserts wait/ready, CLAIM_TIMEOUT=16. Required: `pcpi_valid` high exactly 16 cycles; then `rsp_valid`=1, `rsp_err`=1, `rsp_data`=0.
3. **Late claim.** Stimulus: stub asserts `pcpi_wait` on the 3rd `pcpi_valid` cycle and `pcpi_ready` with `pcpi_rd`=32'hDEADBEEF on cycle 40. Required: no timeout; `rsp_data`=32'hDEADBEEF; `rsp_err`=0.
4. **Response backpressure and `pcpi_wr`=0.** Stimulus: `pcpi_ready` with `pcpi_wr`=0, then hold `rsp_ready`=0 for 5 cycles while `cmd_valid`=1 with a new command. Required: `rsp_data`=0, `rsp_wr`=0, all response fields stable, `cmd_ready`=0. The second command is accepted only after the response handshake.
5. **Reset mid-operation.** Stimulus: pulse `resetn` low mid-ISSUE. Required: `pcpi_valid`=0 immediately (asynchronous); after release, `cmd_ready`=1 and no `rsp_valid` is produced.
6. **Performance counter.** Stimulus: stub asserts `pcpi_ready` on the 10th `pcpi_valid` cycle. Required: `perf_cycles`=10 with `PCPI_PERF_EN` defined, 0 without.

Source files
------------

// File: rtl/pcpi_initiator_if.sv
// pcpi_initiator_if -- bundle of all handshake/bus signals of pcpi_initiator.
//   cmd_*   : command request channel (valid/ready), funct3 + two operands
//   rsp_*   : response channel (valid/ready), result, write flag, timeout flag
//   perf_*  : cycle count of the last PCPI transaction
//   pcpi_*  : PCPI coprocessor bus
// Modports:
//   master : the initiator itself (drives cmd_ready, rsp_*, perf_cycles, pcpi_valid/insn/rs1/rs2)
//   slave  : the surrounding logic plus the coprocessor (drives everything else)
interface pcpi_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_funct3;
  logic [31:0] cmd_rs1;
  logic [31:0] cmd_rs2;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_wr;
  logic        rsp_err;
  logic [15:0] perf_cycles;

  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    input  cmd_valid, cmd_funct3, cmd_rs1, cmd_rs2, rsp_ready,
           pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_wr, rsp_err, perf_cycles,
           pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
  );

  modport slave (
    output cmd_valid, cmd_funct3, cmd_rs1, cmd_rs2, rsp_ready,
           pcpi_wr, pcpi_rd, pcpi_wait, pcpi_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_wr, rsp_err, perf_cycles,
           pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2
  );
endinterface

// File: rtl/pcpi_initiator.sv
// pcpi_initiator -- CPU-side PCPI master for R-type M-extension commands.
// Accepts {funct3, rs1, rs2} on the command channel, encodes pcpi_insn, holds
// the PCPI request until the coprocessor completes (pcpi_ready) or fails to
// claim it within CLAIM_TIMEOUT cycles, then returns the result on the
// response channel. All outputs are registered.
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : pcpi_initiator_if.master (cmd_*, rsp_*, perf_cycles, pcpi_*)
// Parameters: FUNCT7, OPCODE (instruction fields), CLAIM_TIMEOUT (2..255).
// Build option: define PCPI_PERF_EN to enable the perf_cycles counter;
// otherwise perf_cycles reads 0.
module pcpi_initiator #(
  parameter logic [6:0]  FUNCT7        = 7'b0000001,
  parameter logic [6:0]  OPCODE        = 7'b0110011,
  parameter int unsigned CLAIM_TIMEOUT = 16
) (
  input logic              clk,
  input logic              resetn,
  pcpi_initiator_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(CLAIM_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        pcpi_valid_q, pcpi_valid_d;
  logic [31:0] pcpi_insn_q, pcpi_insn_d;
  logic [31:0] pcpi_rs1_q, pcpi_rs1_d;
  logic [31:0] pcpi_rs2_q, pcpi_rs2_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_wr_q, rsp_wr_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        claimed_q, claimed_d;

  always_comb begin
    state_d     = state_q;
    pcpi_insn_d = pcpi_insn_q;
    pcpi_rs1_d  = pcpi_rs1_q;
    pcpi_rs2_d  = pcpi_rs2_q;
    rsp_data_d  = rsp_data_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    claimed_d   = claimed_q;

    unique case (state_q)
      ST_IDLE: begin
        // cmd_ready_q is high whenever state_q is IDLE
        if (bus.cmd_valid) begin
          pcpi_insn_d = {FUNCT7, bus.cmd_rs2[4:0], bus.cmd_rs1[4:0],
                         bus.cmd_funct3, 5'b00000, OPCODE};
          pcpi_rs1_d  = bus.cmd_rs1;
          pcpi_rs2_d  = bus.cmd_rs2;
          cnt_d       = '0;
          claimed_d   = 1'b0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.pcpi_ready) begin
          rsp_data_d = bus.pcpi_wr ? bus.pcpi_rd : '0;
          rsp_wr_d   = bus.pcpi_wr;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (bus.pcpi_wait) begin
          claimed_d = 1'b1;
        end else if (!claimed_q && (cnt_q == CNT_LAST)) begin
          rsp_data_d = '0;
          rsp_wr_d   = 1'b0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else if (!claimed_q) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered copies of the next state so they line up
    // with state_q on every cycle.
    cmd_ready_d  = (state_d == ST_IDLE);
    pcpi_valid_d = (state_d == ST_ISSUE);
    rsp_valid_d  = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b1;
      pcpi_valid_q <= 1'b0;
      pcpi_insn_q  <= '0;
      pcpi_rs1_q   <= '0;
      pcpi_rs2_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_wr_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      cnt_q        <= '0;
      claimed_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      pcpi_valid_q <= pcpi_valid_d;
      pcpi_insn_q  <= pcpi_insn_d;
      pcpi_rs1_q   <= pcpi_rs1_d;
      pcpi_rs2_q   <= pcpi_rs2_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_wr_q     <= rsp_wr_d;
      rsp_err_q    <= rsp_err_d;
      cnt_q        <= cnt_d;
      claimed_q    <= claimed_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.pcpi_valid = pcpi_valid_q;
  assign bus.pcpi_insn  = pcpi_insn_q;
  assign bus.pcpi_rs1   = pcpi_rs1_q;
  assign bus.pcpi_rs2   = pcpi_rs2_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_wr     = rsp_wr_q;
  assign bus.rsp_err    = rsp_err_q;

`ifdef PCPI_PERF_EN
  logic [15:0] perf_cnt_q, perf_cnt_d;
  logic [15:0] perf_cycles_q, perf_cycles_d;
  logic [15:0] perf_inc;

  // perf_cnt_q counts ISSUE cycles already completed; the value snapshotted on
  // RESP entry includes the current (ready or timeout) cycle.
  always_comb begin
    perf_inc      = (perf_cnt_q == '1) ? perf_cnt_q : perf_cnt_q + 16'd1;
    perf_cnt_d    = perf_cnt_q;
    perf_cycles_d = perf_cycles_q;
    if (state_q == ST_IDLE) begin
      perf_cnt_d = '0;
    end else if (state_q == ST_ISSUE) begin
      perf_cnt_d = perf_inc;
      if (state_d == ST_RESP) begin
        perf_cycles_d = perf_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_cnt_q    <= '0;
      perf_cycles_q <= '0;
    end else begin
      perf_cnt_q    <= perf_cnt_d;
      perf_cycles_q <= perf_cycles_d;
    end
  end

  assign bus.perf_cycles = perf_cycles_q;
`else
  assign bus.perf_cycles = '0;
`endif

endmodule

// File: tb/tb_pcpi_initiator.sv
// tb_pcpi_initiator -- directed self-checking bench for pcpi_initiator.
// Inputs are driven and outputs sampled on the falling clock edge; the
// coprocessor is a hand-driven stub.
module tb_pcpi_initiator;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;

  pcpi_initiator_if bus_if();

  pcpi_initiator #(
    .FUNCT7       (7'b0000001),
    .OPCODE       (7'b0110011),
    .CLAIM_TIMEOUT(16)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef PCPI_PERF_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a command and returns on the falling edge right after acceptance
  // (first pcpi_valid cycle).
  task automatic send_cmd(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus_if.cmd_valid  = 1'b1;
    bus_if.cmd_funct3 = f3;
    bus_if.cmd_rs1    = a;
    bus_if.cmd_rs2    = b;
    for (int i = 0; i < 50; i++) begin
      if (bus_if.cmd_ready) break;
      @(negedge clk);
    end
    chk("cmd_ready_seen", {31'd0, bus_if.cmd_ready}, 32'd1);
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic rsp_handshake(input string tag);
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    chk(tag, {31'd0, bus_if.rsp_valid}, 32'd0);
  endtask

  int n;
  int gaps;
  int bad;

  initial begin
    errors = 0;
    checks = 0;
    resetn = 1'b0;
    bus_if.cmd_valid  = 1'b0;
    bus_if.cmd_funct3 = '0;
    bus_if.cmd_rs1    = '0;
    bus_if.cmd_rs2    = '0;
    bus_if.rsp_ready  = 1'b0;
    bus_if.pcpi_wr    = 1'b0;
    bus_if.pcpi_rd    = '0;
    bus_if.pcpi_wait  = 1'b0;
    bus_if.pcpi_ready = 1'b0;

    // ---- reset state
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready",  {31'd0, bus_if.cmd_ready},  32'd1);
    chk("rst_pcpi_valid", {31'd0, bus_if.pcpi_valid}, 32'd0);
    chk("rst_rsp_valid",  {31'd0, bus_if.rsp_valid},  32'd0);
    chk("rst_rsp_err",    {31'd0, bus_if.rsp_err},    32'd0);
    chk("rst_pcpi_insn",  bus_if.pcpi_insn,           32'd0);
    chk("rst_rsp_data",   bus_if.rsp_data,            32'd0);
    chk("rst_perf",       {16'd0, bus_if.perf_cycles}, 32'd0);

    // ---- 1: DIV 20/3, zero-wait coprocessor
    send_cmd(3'b100, 32'd20, 32'd3);
    chk("t1_pcpi_valid", {31'd0, bus_if.pcpi_valid}, 32'd1);
    chk("t1_insn",       bus_if.pcpi_insn,           32'h023A4033);
    chk("t1_rs1",        bus_if.pcpi_rs1,            32'd20);
    chk("t1_rs2",        bus_if.pcpi_rs2,            32'd3);
    chk("t1_cmd_ready",  {31'd0, bus_if.cmd_ready},  32'd0);
    bus_if.pcpi_ready = 1'b1;
    bus_if.pcpi_wr    = 1'b1;
    bus_if.pcpi_rd    = 32'd6;
    @(negedge clk);
    bus_if.pcpi_ready = 1'b0;
    bus_if.pcpi_wr    = 1'b0;
    chk("t1_valid_drop", {31'd0, bus_if.pcpi_valid}, 32'd0);
    chk("t1_rsp_valid",  {31'd0, bus_if.rsp_valid},  32'd1);
    chk("t1_rsp_data",   bus_if.rsp_data,            32'd6);
    chk("t1_rsp_wr",     {31'd0, bus_if.rsp_wr},     32'd1);
    chk("t1_rsp_err",    {31'd0, bus_if.rsp_err},    32'd0);
    chk("t1_perf",       {16'd0, bus_if.perf_cycles}, perf_exp(32'd1));
    rsp_handshake("t1_rsp_done");
    chk("t1_cmd_ready_back", {31'd0, bus_if.cmd_ready}, 32'd1);

    // ---- 2: unclaimed instruction times out after 16 valid cycles
    send_cmd(3'b000, 32'd7, 32'd9);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus_if.pcpi_valid) break;
      n++;
      @(negedge clk);
    end
    chk("t2_valid_cycles", n,                         32'd16);
    chk("t2_rsp_valid",    {31'd0, bus_if.rsp_valid}, 32'd1);
    chk("t2_rsp_err",      {31'd0, bus_if.rsp_err},   32'd1);
    chk("t2_rsp_data",     bus_if.rsp_data,           32'd0);
    chk("t2_rsp_wr",       {31'd0, bus_if.rsp_wr},    32'd0);
    chk("t2_perf",         {16'd0, bus_if.perf_cycles}, perf_exp(32'd16));
    rsp_handshake("t2_rsp_done");

    // ---- 3: late claim, wait dropped again, completion on cycle 40
    send_cmd(3'b001, 32'd11, 32'd12);
    gaps = 0;
    for (int c = 1; c <= 40; c++) begin
      if (!bus_if.pcpi_valid) gaps++;
      if (c == 3) bus_if.pcpi_wait = 1'b1;
      if (c == 6) bus_if.pcpi_wait = 1'b0;
      if (c == 40) begin
        bus_if.pcpi_ready = 1'b1;
        bus_if.pcpi_wr    = 1'b1;
        bus_if.pcpi_rd    = 32'hDEADBEEF;
      end
      @(negedge clk);
    end
    bus_if.pcpi_ready = 1'b0;
    bus_if.pcpi_wr    = 1'b0;
    chk("t3_valid_gaps", gaps,                       32'd0);
    chk("t3_rsp_valid",  {31'd0, bus_if.rsp_valid},  32'd1);
    chk("t3_rsp_data",   bus_if.rsp_data,            32'hDEADBEEF);
    chk("t3_rsp_err",    {31'd0, bus_if.rsp_err},    32'd0);
    chk("t3_valid_drop", {31'd0, bus_if.pcpi_valid}, 32'd0);
    chk("t3_perf",       {16'd0, bus_if.perf_cycles}, perf_exp(32'd40));
    rsp_handshake("t3_rsp_done");

    // ---- 4: pcpi_wr=0 result and response backpressure
    send_cmd(3'b010, 32'd1, 32'd2);
    bus_if.pcpi_ready = 1'b1;
    bus_if.pcpi_wr    = 1'b0;
    bus_if.pcpi_rd    = 32'h12345678;
    @(negedge clk);
    bus_if.pcpi_ready = 1'b0;
    chk("t4_rsp_data", bus_if.rsp_data,         32'd0);
    chk("t4_rsp_wr",   {31'd0, bus_if.rsp_wr},  32'd0);
    chk("t4_rsp_err",  {31'd0, bus_if.rsp_err}, 32'd0);
    bus_if.cmd_valid  = 1'b1;
    bus_if.cmd_funct3 = 3'b101;
    bus_if.cmd_rs1    = 32'd100;
    bus_if.cmd_rs2    = 32'd7;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_data !== 32'd0 || bus_if.rsp_wr !== 1'b0 ||
          bus_if.rsp_err !== 1'b0 || bus_if.cmd_ready !== 1'b0 || bus_if.pcpi_valid !== 1'b0)
        bad++;
      @(negedge clk);
    end
    chk("t4_hold_stable", bad, 32'd0);
    rsp_handshake("t4_rsp_done");
    chk("t4_cmd_ready_after", {31'd0, bus_if.cmd_ready}, 32'd1);
    send_cmd(3'b101, 32'd100, 32'd7);
    chk("t4_second_valid", {31'd0, bus_if.pcpi_valid}, 32'd1);
    chk("t4_second_insn",  bus_if.pcpi_insn,           32'h02725033);
    bus_if.pcpi_ready = 1'b1;
    bus_if.pcpi_wr    = 1'b1;
    bus_if.pcpi_rd    = 32'hA5A50001;
    @(negedge clk);
    bus_if.pcpi_ready = 1'b0;
    bus_if.pcpi_wr    = 1'b0;
    chk("t4_second_data", bus_if.rsp_data, 32'hA5A50001);
    rsp_handshake("t4_second_done");

    // ---- 5: reset mid-ISSUE, then stray coprocessor signals in IDLE
    send_cmd(3'b110, 32'd5, 32'd6);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("t5_async_valid", {31'd0, bus_if.pcpi_valid}, 32'd0);
    chk("t5_async_ready", {31'd0, bus_if.cmd_ready},  32'd1);
    @(negedge clk);
    resetn = 1'b1;
    bus_if.pcpi_ready = 1'b1;
    bus_if.pcpi_wait  = 1'b1;
    bus_if.pcpi_wr    = 1'b1;
    bus_if.pcpi_rd    = 32'h55AA55AA;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus_if.rsp_valid !== 1'b0 || bus_if.pcpi_valid !== 1'b0 || bus_if.cmd_ready !== 1'b1)
        bad++;
    end
    bus_if.pcpi_ready = 1'b0;
    bus_if.pcpi_wait  = 1'b0;
    bus_if.pcpi_wr    = 1'b0;
    chk("t5_idle_quiet", bad,                         32'd0);
    chk("t5_perf_reset", {16'd0, bus_if.perf_cycles}, 32'd0);

    // ---- 6: perf counter, ready on the 10th valid cycle; funct3=7 pass-through
    send_cmd(3'b111, 32'hFFFFFFFF, 32'h0000001F);
    chk("t6_insn", bus_if.pcpi_insn, 32'h03FFF033);
    for (int c = 1; c <= 10; c++) begin
      if (c == 10) begin
        bus_if.pcpi_ready = 1'b1;
        bus_if.pcpi_wr    = 1'b1;
        bus_if.pcpi_rd    = 32'd77;
      end
      @(negedge clk);
    end
    bus_if.pcpi_ready = 1'b0;
    bus_if.pcpi_wr    = 1'b0;
    chk("t6_rsp_data", bus_if.rsp_data,              32'd77);
    chk("t6_perf",     {16'd0, bus_if.perf_cycles},  perf_exp(32'd10));
    rsp_handshake("t6_rsp_done");
    chk("t6_perf_hold", {16'd0, bus_if.perf_cycles}, perf_exp(32'd10));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
